// File: rtl/hub75_pkg.sv
// Shared HUB75 types: pixel format, write-arbiter state encoding and the
// frame geometry helpers also used by hub75_driver.
package hub75_pkg;

  localparam int HUB75_HPIXEL = 64;
  localparam int HUB75_VPIXEL = 64;
  localparam int HUB75_BPP    = 8;

  typedef logic [3*HUB75_BPP-1:0] pixel_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PKT,
    ARB_CLEAR
  } arb_state_t;

  function automatic int frame_size(input int hpixel, input int vpixel);
    return hpixel * vpixel;
  endfunction

  function automatic int addr_width(input int hpixel, input int vpixel);
    return $clog2(hpixel * vpixel);
  endfunction

endpackage

// File: rtl/hub75_rr_arbiter.sv
// Combinational round-robin picker: the first set request after i_ptr
// (wrapping) wins; the grant is one-hot, or zero when nothing requests.
module hub75_rr_arbiter #(
  parameter  int n_p     = 2,
  localparam int idx_w_p = (n_p > 1) ? $clog2(n_p) : 1
) (
  input  logic [n_p-1:0]     i_req,
  input  logic [idx_w_p-1:0] i_ptr,
  output logic [n_p-1:0]     o_grant
);

  logic               found;
  logic [idx_w_p-1:0] idx;

  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 1; off <= n_p; off++) begin
      idx = idx_w_p'((int'(i_ptr) + off) % n_p);
      if (!found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hub75_framebuf_wr_arb.sv
// Frame-buffer write-port scheduler: round-robin with packet locking between
// requesters, plus a clear engine that floods the frame with one colour.
module hub75_framebuf_wr_arb
  import hub75_pkg::*;
#(
  parameter  int hpixel_p     = 64,
  parameter  int vpixel_p     = 64,
  parameter  int bpp_p        = 8,
  parameter  int n_req_p      = 2,
  localparam int frame_size_p = frame_size(hpixel_p, vpixel_p),
  localparam int addr_width_p = addr_width(hpixel_p, vpixel_p)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [n_req_p-1:0]            i_req_valid,
  input  logic [n_req_p-1:0]            i_req_last,
  input  logic [n_req_p*addr_width_p-1:0] i_req_addr,
  input  logic [n_req_p*3*bpp_p-1:0]    i_req_data,
  output logic [n_req_p-1:0]            o_req_ready,
  input  logic                          i_clear,
  input  logic [3*bpp_p-1:0]            i_clear_color,
  output logic                          o_clear_busy,
  output logic [addr_width_p-1:0]       o_wr_addr,
  output logic [3*bpp_p-1:0]            o_wr_data,
  output logic                          o_wr_en
);

  localparam int idx_w_p = (n_req_p > 1) ? $clog2(n_req_p) : 1;
  localparam int pix_w_p = 3 * bpp_p;
  localparam logic [addr_width_p-1:0] last_addr_c = addr_width_p'(frame_size_p - 1);

  // Handshake: a beat transfers in any cycle where valid and ready are both
  // high; ready is combinational from state and valid, never from last.
  arb_state_t                state_q, state_d;
  logic [idx_w_p-1:0]        owner_q, owner_d;
  logic [idx_w_p-1:0]        last_grant_q, last_grant_d;
  logic                      clear_pending_q, clear_pending_d;
  logic [pix_w_p-1:0]        clear_color_q, clear_color_d;
  logic [addr_width_p-1:0]   clr_addr_q, clr_addr_d;
  logic                      wr_en_q, wr_en_d;
  logic [addr_width_p-1:0]   wr_addr_q, wr_addr_d;
  logic [pix_w_p-1:0]        wr_data_q, wr_data_d;

  logic [n_req_p-1:0]        rr_grant;
  logic [n_req_p-1:0]        ready;
  logic [idx_w_p-1:0]        sel;
  logic                      hs;
  logic                      beat_last;
  logic [addr_width_p-1:0]   beat_addr;
  logic [pix_w_p-1:0]        beat_data;

  hub75_rr_arbiter #(.n_p(n_req_p)) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (last_grant_q),
    .o_grant (rr_grant)
  );

  always_comb begin
    ready = '0;
    sel   = owner_q;
    case (state_q)
      ARB_IDLE: begin
        // A pending clear blocks arbitration so no beat slips in first.
        if (!clear_pending_q) begin
          ready = rr_grant;
          for (int k = 0; k < n_req_p; k++) begin
            if (rr_grant[k]) sel = idx_w_p'(k);
          end
        end
      end
      ARB_PKT: ready[owner_q] = i_req_valid[owner_q];
      default: ready = '0;
    endcase
  end

  assign o_req_ready = ready & {n_req_p{rst_n}};
  assign hs          = |ready;
  assign beat_last   = i_req_last[sel];
  assign beat_addr   = i_req_addr[int'(sel)*addr_width_p +: addr_width_p];
  assign beat_data   = i_req_data[int'(sel)*pix_w_p +: pix_w_p];

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    clear_pending_d = clear_pending_q;
    clear_color_d   = clear_color_q;
    clr_addr_d      = clr_addr_q;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;

    if (i_clear && !clear_pending_q) begin
      clear_pending_d = 1'b1;
      clear_color_d   = i_clear_color;
    end

    case (state_q)
      ARB_IDLE: begin
        if (clear_pending_q) begin
          // Address 0 issues on the entry cycle so the fill is gap-free.
          wr_en_d    = 1'b1;
          wr_addr_d  = '0;
          wr_data_d  = clear_color_q;
          clr_addr_d = addr_width_p'(1);
          state_d    = ARB_CLEAR;
        end else if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = beat_addr;
          wr_data_d = beat_data;
          if (beat_last) begin
            last_grant_d = sel;
          end else begin
            owner_d = sel;
            state_d = ARB_PKT;
          end
        end
      end
      ARB_PKT: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = beat_addr;
          wr_data_d = beat_data;
          if (beat_last) begin
            last_grant_d = owner_q;
            state_d      = ARB_IDLE;
          end
        end
      end
      ARB_CLEAR: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = clr_addr_q;
        wr_data_d  = clear_color_q;
        clr_addr_d = clr_addr_q + addr_width_p'(1);
        if (clr_addr_q == last_addr_c) begin
          clear_pending_d = 1'b0;
          clr_addr_d      = '0;
          state_d         = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ARB_IDLE;
      owner_q         <= '0;
      last_grant_q    <= idx_w_p'(n_req_p - 1);
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
      clr_addr_q      <= '0;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      clear_pending_q <= clear_pending_d;
      clear_color_q   <= clear_color_d;
      clr_addr_q      <= clr_addr_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
    end
  end

  assign o_clear_busy = clear_pending_q;
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;

endmodule

// File: tb/tb_hub75_framebuf_wr_arb.sv
// Bench for hub75_framebuf_wr_arb: scenario tasks with a write scoreboard fed
// by accepted beats and a small arbitration reference model.
module tb_hub75_framebuf_wr_arb;

  localparam int HP = 64;
  localparam int VP = 64;
  localparam int BPP = 8;
  localparam int NR = 2;
  localparam int FS = HP * VP;
  localparam int AW = $clog2(FS);
  localparam int PW = 3 * BPP;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*PW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              clear;
  logic [PW-1:0]     clear_color;
  logic              clear_busy;
  logic [AW-1:0]     wr_addr;
  logic [PW-1:0]     wr_data;
  logic              wr_en;

  logic [AW+PW-1:0]  exp_q[$];
  int                n_pass;
  int                n_total;
  bit                mon_en;

  int                m_lg;
  int                m_owner;
  bit                m_pkt;

  hub75_framebuf_wr_arb #(
    .hpixel_p (HP),
    .vpixel_p (VP),
    .bpp_p    (BPP),
    .n_req_p  (NR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (req_valid),
    .i_req_last    (req_last),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .i_clear       (clear),
    .i_clear_color (clear_color),
    .o_clear_busy  (clear_busy),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_wr_en       (wr_en)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [NR-1:0] model_ready(input logic [NR-1:0] v);
    logic [NR-1:0] r;
    int            idx;
    bit            found;
    r     = '0;
    found = 1'b0;
    if (m_pkt) begin
      r[m_owner] = v[m_owner];
    end else begin
      for (int off = 1; off <= NR; off++) begin
        idx = (m_lg + off) % NR;
        if (!found && v[idx]) begin
          r[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_advance(input logic [NR-1:0] hs, input logic [NR-1:0] last);
    for (int k = 0; k < NR; k++) begin
      if (hs[k]) begin
        if (last[k]) begin
          m_lg  = k;
          m_pkt = 1'b0;
        end else begin
          m_owner = k;
          m_pkt   = 1'b1;
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_req(input int k, input bit v, input bit l,
                           input logic [AW-1:0] a, input logic [PW-1:0] d);
    req_valid[k]         = v;
    req_last[k]          = l;
    req_addr[k*AW +: AW] = a;
    req_data[k*PW +: PW] = d;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_last  = '0;
    clear     = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : sb
    logic [AW+PW-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (wr_en !== 1'b1 || {wr_addr, wr_data} !== e)
          $display("FAIL sb_write: got en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h",
                   wr_en, wr_addr, wr_data, e[AW+PW-1:PW], e[PW-1:0]);
        else n_pass++;
      end else begin
        n_total++;
        if (wr_en !== 1'b0)
          $display("FAIL sb_no_write: got en=%b addr=%0d, want en=0", wr_en, wr_addr);
        else n_pass++;
      end
      for (int k = 0; k < NR; k++) begin
        if (req_valid[k] && req_ready[k])
          exp_q.push_back({req_addr[k*AW +: AW], req_data[k*PW +: PW]});
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    mon_en = 1'b0;
    idle_all();
    clear_color = '0;
    req_addr    = '0;
    req_data    = '0;
    req_valid   = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", wr_en); else n_pass++;
    n_total++; if (wr_addr !== '0) $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); else n_pass++;
    n_total++; if (wr_data !== '0) $display("FAIL rst_wr_data: got %h want 0", wr_data); else n_pass++;
    n_total++; if (clear_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", clear_busy); else n_pass++;
    n_total++; if (req_ready !== '0) $display("FAIL rst_ready: got %b want 0", req_ready); else n_pass++;
    req_valid = '0;
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_lg    = NR - 1;
    m_pkt   = 1'b0;
    m_owner = 0;
    mon_en  = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    drive_req(0, 1'b1, 1'b1, AW'(5), 24'hFF0000);
    @(negedge clk);
    n_total++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", req_ready); else n_pass++;
    model_advance(2'b01, req_last);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_total++;
    if (wr_en !== 1'b1 || wr_addr !== AW'(5) || wr_data !== 24'hFF0000)
      $display("FAIL single_write: got en=%b addr=%0d data=%h want en=1 addr=5 data=ff0000",
               wr_en, wr_addr, wr_data);
    else n_pass++;
    @(negedge clk);
    n_total++; if (wr_en !== 1'b0) $display("FAIL single_no_repeat: got en=%b want 0", wr_en); else n_pass++;
  endtask

  task automatic test_alternate();
    logic [NR-1:0] exp_r;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NR; k++)
        drive_req(k, 1'b1, 1'b1, AW'($urandom_range(0, FS-1)), PW'($urandom));
      @(negedge clk);
      exp_r = model_ready(req_valid);
      n_total++;
      if (req_ready !== exp_r) $display("FAIL alt_ready[%0d]: got %b want %b", i, req_ready, exp_r);
      else n_pass++;
      model_advance(exp_r, req_last);
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic test_pkt_lock();
    bit         v0_t[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit         v1_t[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    bit         l1_t[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [1:0] exp_t[8] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_req(0, v0_t[i], 1'b1, AW'(100 + i), PW'(24'h0A0000 + i));
      drive_req(1, v1_t[i], l1_t[i], AW'(200 + i), PW'(24'h000B00 + i));
      @(negedge clk);
      n_total++;
      if (req_ready !== exp_t[i]) $display("FAIL lock_ready[%0d]: got %b want %b", i, req_ready, exp_t[i]);
      else n_pass++;
      model_advance(exp_t[i], req_last);
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] exp_r;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NR; k++)
        drive_req(k, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  AW'($urandom_range(0, FS-1)), PW'($urandom));
      @(negedge clk);
      exp_r = model_ready(req_valid);
      n_total++;
      if (req_ready !== exp_r) $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, exp_r);
      else n_pass++;
      model_advance(exp_r, req_last);
    end
    if (m_pkt) begin
      @(posedge clk); #1;
      for (int k = 0; k < NR; k++)
        drive_req(k, k == m_owner, 1'b1, AW'(k), PW'(24'h55AA55));
      @(negedge clk);
      exp_r = model_ready(req_valid);
      n_total++;
      if (req_ready !== exp_r) $display("FAIL rand_close: got %b want %b", req_ready, exp_r);
      else n_pass++;
      model_advance(exp_r, req_last);
    end
    @(posedge clk); #1;
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clear_idle();
    logic [NR-1:0] exp_r;
    @(posedge clk); #1;
    mon_en      = 1'b0;
    clear       = 1'b1;
    clear_color = 24'h00FF00;
    @(negedge clk);
    n_total++; if (clear_busy !== 1'b0) $display("FAIL clr_busy_t0: got %b want 0", clear_busy); else n_pass++;
    @(posedge clk); #1;
    clear     = 1'b0;
    req_valid = '1;
    req_last  = '1;
    @(negedge clk);
    n_total++;
    if (clear_busy !== 1'b1 || req_ready !== '0 || wr_en !== 1'b0)
      $display("FAIL clr_start: got busy=%b ready=%b en=%b want busy=1 ready=0 en=0",
               clear_busy, req_ready, wr_en);
    else n_pass++;
    for (int i = 0; i < FS; i++) begin
      @(posedge clk); #1;
      if (i == 10) begin
        clear       = 1'b1;
        clear_color = 24'h123456;
      end else begin
        clear = 1'b0;
      end
      if (i == FS - 1) req_valid = '0;
      @(negedge clk);
      n_total++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== 24'h00FF00 ||
          req_ready !== '0 || clear_busy !== (i < FS - 1))
        $display("FAIL clr_write[%0d]: got en=%b addr=%0d data=%h ready=%b busy=%b want en=1 addr=%0d data=00ff00 ready=0 busy=%b",
                 i, wr_en, wr_addr, wr_data, req_ready, clear_busy, i, (i < FS - 1));
      else n_pass++;
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    n_total++;
    if (wr_en !== 1'b0 || clear_busy !== 1'b0)
      $display("FAIL clr_done: got en=%b busy=%b want 0 0", wr_en, clear_busy);
    else n_pass++;
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) drive_req(k, 1'b1, 1'b1, AW'(k + 7), PW'(24'h0F0F0F));
    @(negedge clk);
    exp_r = model_ready(req_valid);
    n_total++;
    if (req_ready !== exp_r) $display("FAIL clr_ptr_kept: got %b want %b", req_ready, exp_r);
    else n_pass++;
    model_advance(exp_r, req_last);
    @(posedge clk); #1;
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clear_mid_pkt();
    bit         v0_t[4] = '{1, 1, 1, 0};
    bit         l0_t[4] = '{0, 0, 1, 0};
    bit         v1_t[4] = '{0, 1, 1, 1};
    bit         c_t[4]  = '{0, 1, 0, 0};
    logic [1:0] exp_t[4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    bit         busy_t[4] = '{0, 0, 1, 1};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive_req(0, v0_t[i], l0_t[i], AW'(300 + i), PW'(24'hC00000 + i));
      drive_req(1, v1_t[i], 1'b1, AW'(400 + i), PW'(24'h00C000 + i));
      clear       = c_t[i];
      clear_color = 24'h0000FF;
      @(negedge clk);
      n_total++;
      if (req_ready !== exp_t[i] || clear_busy !== busy_t[i])
        $display("FAIL midpkt_ready[%0d]: got ready=%b busy=%b want ready=%b busy=%b",
                 i, req_ready, clear_busy, exp_t[i], busy_t[i]);
      else n_pass++;
      model_advance(exp_t[i], req_last);
    end
    for (int i = 0; i < FS; i++) begin
      @(posedge clk); #1;
      mon_en = 1'b0;
      clear  = 1'b0;
      if (i == FS - 1) req_valid = '0;
      @(negedge clk);
      n_total++;
      if (wr_en !== 1'b1 || wr_addr !== AW'(i) || wr_data !== 24'h0000FF || req_ready !== '0)
        $display("FAIL midpkt_clr[%0d]: got en=%b addr=%0d data=%h ready=%b want en=1 addr=%0d data=0000ff ready=0",
                 i, wr_en, wr_addr, wr_data, req_ready, i);
      else n_pass++;
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle_all();
    @(negedge clk);
    n_total++;
    if (wr_en !== 1'b0 || clear_busy !== 1'b0)
      $display("FAIL midpkt_done: got en=%b busy=%b want 0 0", wr_en, clear_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    bit bad;
    @(posedge clk); #1;
    mon_en      = 1'b0;
    clear       = 1'b1;
    clear_color = 24'hAABBCC;
    @(posedge clk); #1;
    clear = 1'b0;
    found = 1'b0;
    for (int i = 0; i < FS + 10 && !found; i++) begin
      @(negedge clk);
      if (wr_en === 1'b1 && wr_addr === AW'(100)) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL rstclr_reach100: got no write at addr 100 want one");
    else n_pass++;
    req_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0)
      $display("FAIL rstclr_outputs: got en=%b addr=%0d data=%h want 0 0 0", wr_en, wr_addr, wr_data);
    else n_pass++;
    n_total++; if (clear_busy !== 1'b0) $display("FAIL rstclr_busy: got %b want 0", clear_busy); else n_pass++;
    n_total++; if (req_ready !== '0) $display("FAIL rstclr_ready: got %b want 0", req_ready); else n_pass++;
    repeat (2) @(posedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_lg  = NR - 1;
    m_pkt = 1'b0;
    bad   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || clear_busy !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL rstclr_quiet: got a write or busy after reset want none");
    else n_pass++;
    @(posedge clk); #1;
    mon_en = 1'b1;
    for (int k = 0; k < NR; k++) drive_req(k, 1'b1, 1'b1, AW'(k + 20), PW'(24'h010203));
    @(negedge clk);
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL rstclr_ptr: got %b want 01", req_ready);
    else n_pass++;
    model_advance(2'b01, req_last);
    @(posedge clk); #1;
    idle_all();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_alternate();
    test_pkt_lock();
    test_back_to_back();
    test_clear_idle();
    test_clear_mid_pkt();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
